// File: rtl/ps2_pkg.sv
// Shared PS/2 frame and mouse-packet definitions for the pointer receiver.
package ps2_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam int BTN_LEFT = 0;
  localparam int SYNC     = 3;
  localparam int X_SIGN   = 4;
  localparam int X_OVF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } byte_state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_byte_receiver.sv
// Synchronises the PS/2 lines and turns 11-bit frames into bytes, with an
// inactivity timeout that also covers gaps between bytes of a packet.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the odd-parity bit
// ST_STOP   | sampling the stop bit, then emitting byte or error
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       pkt_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_meta_q, clk_meta_d, sync_clk_q, sync_clk_d, sync_clk_prev_q, sync_clk_prev_d;
  logic data_meta_q, data_meta_d, sync_data_q, sync_data_d;
  byte_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic byte_valid_q, byte_valid_d;
  logic byte_error_q, byte_error_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic fall, active, expire;

  assign fall   = sync_clk_prev_q & ~sync_clk_q;
  assign active = (state_q != ST_IDLE) || pkt_busy;
  assign expire = !fall && active && (tmo_q == TO_LAST);

  always_comb begin
    clk_meta_d      = ps2_clock;
    sync_clk_d      = clk_meta_q;
    sync_clk_prev_d = sync_clk_q;
    data_meta_d     = ps2_data;
    sync_data_d     = data_meta_q;
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_err_d       = par_err_q;
    byte_data_d     = byte_data_q;
    byte_valid_d    = 1'b0;
    byte_error_d    = 1'b0;

    if (fall) tmo_d = '0;
    else if (active) tmo_d = tmo_q + TW'(1);
    else tmo_d = '0;

    if (expire) begin
      state_d      = ST_IDLE;
      tmo_d        = '0;
      byte_error_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sync_data_q == START_BIT) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            byte_error_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {sync_data_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_err_d = !odd_parity_ok(shift_q, sync_data_q);
          state_d   = ST_STOP;
        end
        ST_STOP: begin
          if (sync_data_q == STOP_BIT && !par_err_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            byte_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sync flops reset to the idle-high line level so releasing reset cannot fake an edge.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      clk_meta_q      <= 1'b1;
      sync_clk_q      <= 1'b1;
      sync_clk_prev_q <= 1'b1;
      data_meta_q     <= 1'b1;
      sync_data_q     <= 1'b1;
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      tmo_q           <= '0;
      byte_valid_q    <= 1'b0;
      byte_error_q    <= 1'b0;
      byte_data_q     <= '0;
    end else begin
      clk_meta_q      <= clk_meta_d;
      sync_clk_q      <= sync_clk_d;
      sync_clk_prev_q <= sync_clk_prev_d;
      data_meta_q     <= data_meta_d;
      sync_data_q     <= sync_data_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_err_q       <= par_err_d;
      tmo_q           <= tmo_d;
      byte_valid_q    <= byte_valid_d;
      byte_error_q    <= byte_error_d;
      byte_data_q     <= byte_data_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_error = byte_error_q;

endmodule

// File: rtl/ps2_mouse_receiver.sv
// Assembles 3-byte PS/2 mouse packets and keeps a clamped absolute X position
// plus the left-button state for the pointer consumer.
module ps2_mouse_receiver
  import ps2_pkg::*;
#(
  parameter logic [15:0] X_MAX          = 16'd639,
  parameter logic [15:0] X_RESET        = 16'd0,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_valid,
  output logic        frame_error
);

  logic       byte_valid, byte_error;
  logic [7:0] byte_data;

  logic [1:0]  idx_q, idx_d;
  logic        btn_q, btn_d, sign_q, sign_d, ovf_q, ovf_d;
  logic [7:0]  dx_q, dx_d;
  logic [15:0] x_q, x_d;
  logic        btn_n_q, btn_n_d, pv_q, pv_d, fe_q, fe_d;
  logic signed [17:0] delta, sum;

  ps2_byte_receiver #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock      (clock),
    .reset_     (reset_),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .pkt_busy   (idx_q != 2'd0),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_error (byte_error)
  );

  // An overflowed X report carries no usable magnitude, so it moves nothing.
  assign delta = ovf_q ? 18'sd0 : $signed({{9{sign_q}}, sign_q, dx_q});
  assign sum   = $signed({2'b00, x_q}) + delta;

  always_comb begin
    idx_d   = idx_q;
    btn_d   = btn_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    dx_d    = dx_q;
    x_d     = x_q;
    btn_n_d = btn_n_q;
    pv_d    = 1'b0;
    fe_d    = 1'b0;

    if (byte_error) begin
      idx_d = 2'd0;
      fe_d  = 1'b1;
    end else if (byte_valid) begin
      unique case (idx_q)
        2'd0: begin
          if (byte_data[SYNC]) begin
            btn_d  = byte_data[BTN_LEFT];
            sign_d = byte_data[X_SIGN];
            ovf_d  = byte_data[X_OVF];
            idx_d  = 2'd1;
          end else begin
            fe_d = 1'b1;
          end
        end
        2'd1: begin
          dx_d  = byte_data;
          idx_d = 2'd2;
        end
        default: begin
          idx_d   = 2'd0;
          pv_d    = 1'b1;
          btn_n_d = ~btn_q;
          if (sum < 18'sd0) x_d = 16'd0;
          else if (sum > $signed({2'b00, X_MAX})) x_d = X_MAX;
          else x_d = sum[15:0];
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      idx_q   <= 2'd0;
      btn_q   <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dx_q    <= '0;
      x_q     <= X_RESET;
      btn_n_q <= 1'b1;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      btn_q   <= btn_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      dx_q    <= dx_d;
      x_q     <= x_d;
      btn_n_q <= btn_n_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
    end
  end

  assign mouse_x        = x_q;
  assign mouse_pressed_ = btn_n_q;
  assign packet_valid   = pv_q;
  assign frame_error    = fe_q;

endmodule
